// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among several requesters.
// A packet keeps the transmitter locked until its last word, or until the owner stalls too long.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int WORD         = 8,
    parameter int GAP_CLKS     = 2,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic                      i_Clock,
    input  logic                      i_Rst_n,
    input  logic [NUM_REQ-1:0]        i_Req_Valid,
    input  logic [NUM_REQ*WORD-1:0]   i_Req_Data,
    input  logic [NUM_REQ-1:0]        i_Req_Last,
    output logic [NUM_REQ-1:0]        o_Req_Ready,
    output logic                      o_Tx_DV,
    output logic [WORD-1:0]           o_Tx_Byte,
    input  logic                      i_Tx_Active,
    input  logic                      i_Tx_Done,
    output logic [NUM_REQ-1:0]        o_Grant,
    output logic                      o_Busy
);
    // state     | meaning
    // S_IDLE    | no owner; arbitrate when the transmitter is idle
    // S_LOAD    | one-cycle strobe to the transmitter, ready to the owner
    // S_WAIT_DONE | frame in flight; wait for the done rising edge
    // S_GAP     | settle clocks after done; then next word, release or hold
    // S_HOLD    | owner mid-packet but not valid; lock timeout running

    localparam int RR_W  = $clog2(NUM_REQ);
    localparam int GAP_W = $clog2(GAP_CLKS + 1);
    localparam int TO_W  = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
    localparam logic [GAP_W-1:0]   GAP_LOAD = GAP_W'(GAP_CLKS - 1);
    localparam logic [TO_W-1:0]    TO_LAST  = TO_W'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_DONE,
        S_GAP,
        S_HOLD
    } state_t;

    state_t            state;
    logic [RR_W-1:0]   rr_ptr;
    logic [RR_W-1:0]   owner;
    logic [RR_W-1:0]   owner_nxt;
    logic [RR_W-1:0]   arb_start;
    logic [RR_W-1:0]   arb_idx;
    logic [RR_W-1:0]   cand;
    logic              arb_found;
    logic [WORD-1:0]   arb_data;
    logic [WORD-1:0]   owner_data;
    logic              owner_valid;
    logic              lock_end;
    logic              done_q;
    logic              done_rise;
    logic [GAP_W-1:0]  gap_cnt;
    logic [TO_W-1:0]   to_cnt;

    assign owner_nxt   = (owner == RR_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
    assign owner_valid = i_Req_Valid[owner];
    assign owner_data  = i_Req_Data[int'(owner)*WORD +: WORD];
    assign done_rise   = i_Tx_Done & ~done_q;
    assign o_Busy      = (state != S_IDLE);

    // At a packet end in GAP the pointer advances this same cycle, so search from owner+1.
    assign arb_start = (state == S_GAP) ? owner_nxt : rr_ptr;

    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = RR_W'((int'(arb_start) + i) % NUM_REQ);
            if (!arb_found && i_Req_Valid[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    assign arb_data = i_Req_Data[int'(arb_idx)*WORD +: WORD];

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state       <= S_IDLE;
            rr_ptr      <= '0;
            owner       <= '0;
            lock_end    <= 1'b0;
            done_q      <= 1'b0;
            gap_cnt     <= '0;
            to_cnt      <= '0;
            o_Req_Ready <= '0;
            o_Tx_DV     <= 1'b0;
            o_Tx_Byte   <= '0;
            o_Grant     <= '0;
        end else begin
            done_q      <= i_Tx_Done;
            o_Tx_DV     <= 1'b0;
            o_Req_Ready <= '0;
            case (state)
                S_IDLE: begin
                    if (!i_Tx_Active && arb_found) begin
                        owner       <= arb_idx;
                        o_Grant     <= ONE_HOT0 << arb_idx;
                        o_Tx_Byte   <= arb_data;
                        lock_end    <= i_Req_Last[arb_idx];
                        o_Tx_DV     <= 1'b1;
                        o_Req_Ready <= ONE_HOT0 << arb_idx;
                        state       <= S_LOAD;
                    end
                end
                S_LOAD: state <= S_WAIT_DONE;
                S_WAIT_DONE: begin
                    if (done_rise) begin
                        gap_cnt <= GAP_LOAD;
                        state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end else if (lock_end) begin
                        rr_ptr  <= owner_nxt;
                        o_Grant <= '0;
                        state   <= S_IDLE;
                        if (!i_Tx_Active && arb_found) begin
                            owner       <= arb_idx;
                            o_Grant     <= ONE_HOT0 << arb_idx;
                            o_Tx_Byte   <= arb_data;
                            lock_end    <= i_Req_Last[arb_idx];
                            o_Tx_DV     <= 1'b1;
                            o_Req_Ready <= ONE_HOT0 << arb_idx;
                            state       <= S_LOAD;
                        end
                    end else if (owner_valid) begin
                        o_Tx_Byte   <= owner_data;
                        lock_end    <= i_Req_Last[owner];
                        o_Tx_DV     <= 1'b1;
                        o_Req_Ready <= o_Grant;
                        state       <= S_LOAD;
                    end else begin
                        to_cnt <= '0;
                        state  <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    // Owner presenting on the timeout cycle still keeps the lock.
                    if (owner_valid) begin
                        o_Tx_Byte   <= owner_data;
                        lock_end    <= i_Req_Last[owner];
                        o_Tx_DV     <= 1'b1;
                        o_Req_Ready <= o_Grant;
                        state       <= S_LOAD;
                    end else if ((LOCK_TIMEOUT != 0) && (to_cnt == TO_LAST)) begin
                        o_Grant <= '0;
                        rr_ptr  <= owner_nxt;
                        state   <= S_IDLE;
                    end else if (to_cnt != '1) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester drivers, a behavioural 8N1 transmitter and a
// packet-level round-robin model that predicts the transmitted word order.
module tb_uart_tx_arbiter;
    localparam int NR  = 3;
    localparam int WD  = 8;
    localparam int GAP = 2;
    localparam int LTO = 16;
    localparam int CPB = 4;

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         stall;
    } word_t;

    typedef struct {
        int         req;
        logic [7:0] data;
    } exp_t;

    logic              i_Clock = 1'b0;
    logic              rst_n   = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*WD-1:0]  req_data  = '0;
    logic [NR-1:0]     req_last  = '0;
    logic [NR-1:0]     o_Req_Ready;
    logic              o_Tx_DV;
    logic [WD-1:0]     o_Tx_Byte;
    logic              tx_active = 1'b0;
    logic              tx_done   = 1'b0;
    logic [NR-1:0]     o_Grant;
    logic              o_Busy;

    uart_tx_arbiter #(
        .NUM_REQ(NR), .WORD(WD), .GAP_CLKS(GAP), .LOCK_TIMEOUT(LTO)
    ) dut (
        .i_Clock     (i_Clock),
        .i_Rst_n     (rst_n),
        .i_Req_Valid (req_valid),
        .i_Req_Data  (req_data),
        .i_Req_Last  (req_last),
        .o_Req_Ready (o_Req_Ready),
        .o_Tx_DV     (o_Tx_DV),
        .o_Tx_Byte   (o_Tx_Byte),
        .i_Tx_Active (tx_active),
        .i_Tx_Done   (tx_done),
        .o_Grant     (o_Grant),
        .o_Busy      (o_Busy)
    );

    always #5 i_Clock = ~i_Clock;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge i_Clock) cyc <= cyc + 1;

    word_t      wq [NR][$];
    exp_t       exp_q [$];
    logic [9:0] frames [$];
    bit         acc [NR];
    bit         armed [NR];
    int         hold_left [NR];
    int         done_len = 1;
    int         done_cyc = 0;
    int         dv_cyc = 0;
    int         gdrop_cyc = 0;
    int         tx_tick = 0;
    logic [9:0] tx_frame = '0;
    logic [9:0] tx_cap = '0;
    logic       tx_line = 1'b1;
    int         done_left = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic add_word(input int r, input logic [7:0] d, input logic l, input int s);
        word_t w;
        w.data = d; w.last = l; w.stall = s;
        wq[r].push_back(w);
    endtask

    function automatic bit queues_empty();
        bit e;
        e = 1'b1;
        for (int r = 0; r < NR; r++) if (wq[r].size() != 0) e = 1'b0;
        return e;
    endfunction

    // Reference: whole packets, owner chosen round-robin among requesters with work left.
    task automatic build_exp();
        int   pos [NR];
        int   p;
        int   w;
        int   r;
        exp_t e;
        p = 0;
        for (int i = 0; i < NR; i++) pos[i] = 0;
        for (int g = 0; g < 200; g++) begin
            w = -1;
            for (int k = 0; k < NR; k++) begin
                r = (p + k) % NR;
                if (w < 0 && pos[r] < wq[r].size()) w = r;
            end
            if (w < 0) break;
            do begin
                e.req = w; e.data = wq[w][pos[w]].data;
                exp_q.push_back(e);
                pos[w]++;
            end while (!wq[w][pos[w]-1].last && pos[w] < wq[w].size());
            p = (w + 1) % NR;
        end
    endtask

    task automatic clear_bench();
        for (int r = 0; r < NR; r++) begin
            wq[r].delete();
            acc[r] = 1'b0; armed[r] = 1'b0; hold_left[r] = 0;
        end
        req_valid = '0; req_last = '0; req_data = '0;
        exp_q.delete();
        frames.delete();
    endtask

    task automatic do_reset();
        @(negedge i_Clock);
        rst_n = 1'b0;
        #1;
        clear_bench();
        chk("rst_dv", o_Tx_DV, 0);
        chk("rst_byte", o_Tx_Byte, 0);
        chk("rst_grant", o_Grant, 0);
        chk("rst_busy", o_Busy, 0);
        chk("rst_ready", o_Req_Ready, 0);
        repeat (2) @(negedge i_Clock);
        rst_n = 1'b1;
        #2;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (n < budget && !(exp_q.size() == 0 && !o_Busy && !tx_active && !tx_done &&
                               req_valid == '0 && queues_empty())) begin
            @(negedge i_Clock); #2;
            n++;
        end
        chk("drain_exp", exp_q.size(), 0);
        chk("drain_busy", o_Busy, 0);
    endtask

    task automatic wait_frames(input int nf, input int budget);
        int n;
        n = 0;
        while (n < budget && frames.size() < nf) begin
            @(negedge i_Clock); #2;
            n++;
        end
        chk("frames_reached", (frames.size() >= nf), 1);
    endtask

    // Requester drivers: pop on accept, then present the next word after its stall.
    initial begin : drv
        forever begin
            @(negedge i_Clock);
            for (int r = 0; r < NR; r++) begin
                if (acc[r]) begin
                    acc[r] = 1'b0;
                    if (wq[r].size() > 0) void'(wq[r].pop_front());
                    req_valid[r] = 1'b0;
                    armed[r] = 1'b0;
                end
                if (!req_valid[r] && wq[r].size() > 0) begin
                    if (!armed[r]) begin
                        hold_left[r] = wq[r][0].stall;
                        armed[r] = 1'b1;
                    end
                    if (hold_left[r] > 0) hold_left[r]--;
                    else begin
                        req_valid[r] = 1'b1;
                        req_last[r]  = wq[r][0].last;
                        req_data[r*WD +: WD] = wq[r][0].data;
                    end
                end
                if (req_valid[r] && o_Req_Ready[r]) acc[r] = 1'b1;
            end
        end
    end

    // Behavioural 8N1 transmitter with CPB clocks per bit and a done pulse of done_len clocks.
    initial begin : tx_model
        forever begin
            @(negedge i_Clock);
            if (!rst_n) begin
                tx_active = 1'b0; tx_done = 1'b0; tx_line = 1'b1; tx_tick = 0; done_left = 0;
            end else begin
                if (done_left > 0) begin
                    done_left--;
                    if (done_left == 0) tx_done = 1'b0;
                end
                if (tx_active) begin
                    tx_tick++;
                    if (tx_tick == 10*CPB) begin
                        tx_active = 1'b0; tx_line = 1'b1; tx_done = 1'b1;
                        done_left = done_len; done_cyc = cyc;
                        frames.push_back(tx_cap);
                    end else begin
                        tx_line = tx_frame[tx_tick/CPB];
                        if (tx_tick % CPB == CPB/2) tx_cap[tx_tick/CPB] = tx_line;
                    end
                end else if (o_Tx_DV) begin
                    tx_active = 1'b1;
                    tx_frame  = {1'b1, o_Tx_Byte, 1'b0};
                    tx_tick   = 0;
                    tx_cap    = '0;
                    tx_line   = tx_frame[0];
                end
            end
        end
    end

    initial begin : mon
        logic [NR-1:0] prev_grant;
        exp_t e;
        prev_grant = '0;
        forever begin
            @(negedge i_Clock);
            if (prev_grant != '0 && o_Grant == '0) gdrop_cyc = cyc;
            prev_grant = o_Grant;
            if (rst_n && o_Tx_DV) begin
                dv_cyc = cyc;
                chk("ready_eq_grant", o_Req_Ready, o_Grant);
                chk("busy_at_dv", o_Busy, 1);
                chk("exp_pending", (exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("tx_byte", o_Tx_Byte, e.data);
                    chk("tx_grant", o_Grant, 32'd1 << e.req);
                end
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
        $fatal(1, "time limit");
    end

    initial begin : main
        int         seq [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
        logic [9:0] ef;
        int         d;
        int         n;
        int         total;
        int         np;
        int         nw;
        int         st;

        // Single word, serial framing and pointer advance
        do_reset();
        done_len = 1;
        add_word(1, 8'hA5, 1'b1, 0);
        build_exp();
        wait_idle(300);
        chk("single_grant_idle", o_Grant, 0);
        chk("single_rr", dut.rr_ptr, 2);
        for (int i = 0; i < 10; i++) ef[i] = seq[i][0];
        chk("single_nframes", frames.size(), 1);
        if (frames.size() > 0) chk("single_serial", frames[0], ef);

        // Packet lock against a competing requester
        do_reset();
        add_word(0, 8'h11, 1'b0, 0);
        add_word(0, 8'h22, 1'b0, 0);
        add_word(0, 8'h33, 1'b1, 0);
        add_word(2, 8'h99, 1'b1, 0);
        build_exp();
        wait_idle(600);

        // Fairness: every requester has two single-word packets
        do_reset();
        for (int k = 0; k < 2; k++)
            for (int r = 0; r < NR; r++) add_word(r, 8'(8'h50 + 16*k + r), 1'b1, 0);
        build_exp();
        wait_idle(1000);

        // Lock timeout: owner stalls mid-packet, waiting requester gets the line after release
        do_reset();
        add_word(1, 8'h40, 1'b0, 0);
        add_word(1, 8'h41, 1'b1, 300);
        add_word(0, 8'h5A, 1'b1, 5);
        exp_q.push_back('{req: 1, data: 8'h40});
        exp_q.push_back('{req: 0, data: 8'h5A});
        exp_q.push_back('{req: 1, data: 8'h41});
        gdrop_cyc = 0;
        wait_frames(1, 200);
        d = done_cyc;
        n = 0;
        while (n < 100 && gdrop_cyc <= d) begin @(negedge i_Clock); #2; n++; end
        chk("hold_release_time", gdrop_cyc - d, GAP + LTO + 1);
        wait_idle(1000);

        // Owner returns on the timeout cycle and keeps the lock
        do_reset();
        add_word(1, 8'h40, 1'b0, 0);
        add_word(1, 8'h41, 1'b1, 1000);
        add_word(0, 8'h5A, 1'b1, 5);
        exp_q.push_back('{req: 1, data: 8'h40});
        exp_q.push_back('{req: 1, data: 8'h41});
        exp_q.push_back('{req: 0, data: 8'h5A});
        wait_frames(1, 200);
        hold_left[1] = GAP + LTO - 1;
        wait_idle(1000);

        // Done held for two clocks: one gap, next strobe GAP clocks after the edge
        do_reset();
        done_len = 2;
        add_word(0, 8'h5C, 1'b0, 0);
        add_word(0, 8'h3A, 1'b1, 0);
        build_exp();
        wait_frames(1, 200);
        d = done_cyc;
        n = 0;
        while (n < 50 && dv_cyc <= d) begin @(negedge i_Clock); #2; n++; end
        chk("dv_after_done", dv_cyc - d, GAP + 1);
        wait_idle(300);
        chk("done2_frames", frames.size(), 2);

        // Asynchronous reset in the middle of data bit 3
        do_reset();
        done_len = 1;
        add_word(0, 8'hC3, 1'b1, 0);
        build_exp();
        n = 0;
        while (n < 200 && !(tx_active && tx_tick == 4*CPB + 1)) begin @(negedge i_Clock); #2; n++; end
        chk("reach_bit3", (tx_active && tx_tick == 4*CPB + 1), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_dv", o_Tx_DV, 0);
        chk("arst_byte", o_Tx_Byte, 0);
        chk("arst_grant", o_Grant, 0);
        chk("arst_busy", o_Busy, 0);
        chk("arst_ready", o_Req_Ready, 0);
        clear_bench();
        repeat (2) @(negedge i_Clock);
        rst_n = 1'b1;
        #2;
        add_word(0, 8'hC3, 1'b1, 0);
        build_exp();
        wait_idle(300);
        chk("c3_frames", frames.size(), 1);
        if (frames.size() > 0) chk("c3_frame", frames[0], {1'b1, 8'hC3, 1'b0});

        // Randomised packets with short mid-packet stalls
        done_len = 2;
        for (int round = 0; round < 4; round++) begin
            do_reset();
            total = 0;
            for (int r = 0; r < NR; r++) begin
                np = int'($urandom_range(0, 3));
                for (int p = 0; p < np; p++) begin
                    nw = int'($urandom_range(1, 3));
                    for (int w = 0; w < nw; w++) begin
                        st = 0;
                        if (w != 0 && $urandom_range(0, 1) == 1) st = int'($urandom_range(0, 52));
                        add_word(r, 8'($urandom), (w == nw - 1), st);
                        total++;
                    end
                end
            end
            build_exp();
            wait_idle(8000);
            chk("rand_frames", frames.size(), total);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
